fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of hazard detection and decode.
- Owns the PC and drives the instruction-memory address.
- Captures the fetched word and PC+4 into IF/ID.
- Obeys the hazard unit's PCWrite, IFID_Write and IF_Flush.
- Accepts branch/jump redirects resolved in ID.
- Provides stall/flush counters and a stall watchdog for debugging pipeline lockups.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the stall and flush counters
MAX_STALL, 16, consecutive stalled cycles that trip the watchdog (range 1..255)

Ports:
Clk  input  1  clock, all state updates on posedge
Reset_n  input  1  synchronous, active-low reset
PCWrite  input  1  1 = PC may advance; 0 = hold PC (stall)
IFID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID
IF_Flush  input  1  1 = squash IF/ID (load NOP)
redirect_valid  input  1  branch taken or jump resolved in ID
redirect_target  input  32  new PC for the redirect
imem_data  input  32  instruction word at imem_addr, combinational same-cycle read
imem_addr  output  32  current PC, combinational from the PC register
IFID_Instruction  output  32  registered instruction to ID
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  1 = IF/ID holds a real instruction
stall_count  output  CNT_W  cycles with PCWrite=0, saturating
flush_count  output  CNT_W  cycles in which IF/ID was squashed, saturating
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock Clk; reset Reset_n is synchronous and active-low.
- Reset takes priority over all inputs, including mid-stall and mid-redirect. At a posedge with Reset_n=0:
  - PC=RESET_PC
  - IFID_Instruction=32'h0 (NOP), IFID_PCPlus4=0, IFID_Valid=0
  - stall_count=0, flush_count=0, stall run counter=0, stall_timeout=0
- imem_addr=PC at all times, so the first fetch after reset is RESET_PC.
- redirect_accept = redirect_valid AND PCWrite. A redirect while PCWrite=0 is ignored; ID re-presents it after the stall.
- PC next-state, first match wins:
  - redirect_accept: PC={redirect_target[31:2],2'b00}. Low two bits are forced to zero.
  - PCWrite=0: hold.
  - Otherwise: PC+4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000.
- IF/ID next-state, first match wins:
  - IF_Flush=1 or redirect_accept: Instruction=0, PCPlus4=0, Valid=0. The squash overrides IFID_Write=0.
  - IFID_Write=0: hold all three fields.
  - Otherwise: Instruction=imem_data, PCPlus4=PC+4, Valid=1.
- Latency:
  - Instruction at PC N appears on IFID outputs one cycle after imem_addr=N.
  - Redirect penalty is one bubble: the wrong-path word is squashed, the target is fetched the next cycle.
- Counters:
  - stall_count increments on each posedge with PCWrite=0.
  - flush_count increments on each posedge where the squash branch is taken.
  - Both saturate at all-ones and do not wrap.
- Watchdog, 8-bit run counter:
  - Increments on PCWrite=0 and saturates at MAX_STALL.
  - Clears on PCWrite=1.
  - stall_timeout sets at the posedge that moves the run counter to MAX_STALL.
  - stall_timeout stays set until reset.
- Small FSM {RUN, STALLED, TIMED_OUT}:
  - RUN goes to STALLED on PCWrite=0.
  - STALLED goes back to RUN on PCWrite=1.
  - STALLED goes to TIMED_OUT when the run counter reaches MAX_STALL.
  - TIMED_OUT is left only by reset; fetch keeps operating normally while in it.

Decomposition:
- Shared package holds:
  - NOP_INSTR=32'h0
  - default RESET_PC
  - FSM state encoding (RUN=2'd0, STALLED=2'd1, TIMED_OUT=2'd2)
- One sub-module, if_id_register: holds Instruction, PCPlus4 and Valid, with write-enable, flush and reset inputs.
- PC logic, counters and watchdog stay in fetch_stage.

Test Plan:
- Reset for 2 cycles with imem_data=0x8C080004, then release: imem_addr=0x0 and IFID_Valid=0. After the first posedge: IFID_Instruction=0x8C080004, IFID_PCPlus4=0x4, IFID_Valid=1.
- At PC=0x10, hold PCWrite=0 and IFID_Write=0 for 3 cycles: PC stays 0x10, IF/ID unchanged, stall_count=3. Release: PC=0x14 next edge.
- At PC=0x20, redirect_valid=1 with target=0x107: next PC=0x104, IFID_Instruction=0, IFID_Valid=0, flush_count+1. The following edge loads the word at 0x104 with IFID_PCPlus4=0x108.
- redirect_valid=1 with PCWrite=0 at PC=0x30: PC holds 0x30, no flush, flush_count unchanged. IF_Flush=1 with IFID_Write=0: IF/ID is squashed (Valid=0).
- Redirect to 0xFFFFFFFC, then one normal cycle: PC=0x0, IFID_PCPlus4=0x0, IFID_Valid=1.
- MAX_STALL=4:
  - PCWrite=0 for 3 cycles then 1: stall_timeout=0.
  - PCWrite=0 for 4 cycles: stall_timeout=1 after the 4th edge and remains 1 after PCWrite returns to 1.
  - Reset clears stall_timeout.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: the NOP encoding, the
// default reset PC and the watchdog FSM state encoding.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_STALLED   = 2'd1;
  localparam logic [1:0] ST_TIMED_OUT = 2'd2;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction word, PC+4 and a valid bit, with a
// squash input that wins over the write enable.
module if_id_register
  import fetch_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        i_write_en,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_write_en) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, redirect handling, IF/ID
// register, saturating stall/flush counters and a stall watchdog.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             PCWrite,
  input  logic             IFID_Write,
  input  logic             IF_Flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      IFID_Instruction,
  output logic [31:0]      IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout
);

  localparam logic [7:0]       RUN_MAX = 8'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic [7:0]       r_run_cnt;
  logic [1:0]       r_state;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect_accept;
  logic        w_squash;
  logic [7:0]  w_run_next;
  logic [1:0]  w_state_next;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_target          = redirect_target & 32'hFFFF_FFFC;
  // A redirect during a stall is dropped; ID keeps presenting it until PCWrite returns.
  assign w_redirect_accept = redirect_valid & PCWrite;
  assign w_squash          = IF_Flush | w_redirect_accept;

  always_comb begin
    w_run_next = r_run_cnt;
    if (PCWrite)
      w_run_next = 8'd0;
    else if (r_run_cnt != RUN_MAX)
      w_run_next = r_run_cnt + 8'd1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:
        if (!PCWrite)
          w_state_next = (w_run_next == RUN_MAX) ? ST_TIMED_OUT : ST_STALLED;
      ST_STALLED:
        if (PCWrite)
          w_state_next = ST_RUN;
        else if (w_run_next == RUN_MAX)
          w_state_next = ST_TIMED_OUT;
      ST_TIMED_OUT:
        w_state_next = ST_TIMED_OUT;
      default:
        w_state_next = ST_RUN;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // tested first, ahead of every stall, flush and redirect condition.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pc          <= RESET_PC;
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_run_cnt     <= 8'd0;
      r_state       <= ST_RUN;
    end else begin
      if (w_redirect_accept)
        r_pc <= w_target;
      else if (PCWrite)
        r_pc <= w_pc_plus4;

      if (!PCWrite && r_stall_count != CNT_MAX)
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_squash && r_flush_count != CNT_MAX)
        r_flush_count <= r_flush_count + CNT_W'(1);

      r_run_cnt <= w_run_next;
      r_state   <= w_state_next;
    end
  end

  if_id_register u_if_id (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .i_write_en (IFID_Write),
    .i_flush    (w_squash),
    .i_instr    (imem_data),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (IFID_Instruction),
    .o_pc_plus4 (IFID_PCPlus4),
    .o_valid    (IFID_Valid)
  );

  assign imem_addr     = r_pc;
  assign stall_count   = r_stall_count;
  assign flush_count   = r_flush_count;
  assign stall_timeout = (r_state == ST_TIMED_OUT);

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: each vector's expected post-edge state
// is queued when the stimulus is driven and popped after the clock edge.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        PCWrite, IFID_Write, IF_Flush, redirect_valid;
  logic [31:0] redirect_target, imem_data, imem_addr;
  logic [31:0] IFID_Instruction, IFID_PCPlus4;
  logic        IFID_Valid, stall_timeout;
  logic [31:0] stall_count, flush_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 Clk = ~Clk;

  // Instruction memory: word at address a is 0x8C080004 + a.
  assign imem_data = 32'h8C08_0004 + imem_addr;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(32), .MAX_STALL(4)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .PCWrite          (PCWrite),
    .IFID_Write       (IFID_Write),
    .IF_Flush         (IF_Flush),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_data        (imem_data),
    .imem_addr        (imem_addr),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .stall_count      (stall_count),
    .flush_count      (flush_count),
    .stall_timeout    (stall_timeout)
  );

  typedef struct {
    logic        rst_n, pcw, ifw, flush, rv;
    logic [31:0] tgt;
    logic [31:0] addr, instr, pc4;
    logic        valid;
    logic [31:0] scnt, fcnt;
    logic        to;
  } vec_t;

  vec_t vecs[32];
  vec_t sb[$];

  function automatic vec_t mk(input logic r, p, w, f, rv, input logic [31:0] t,
                              input logic [31:0] a, i, p4, input logic vl,
                              input logic [31:0] sc, fc, input logic to);
    vec_t v;
    v.rst_n = r; v.pcw = p; v.ifw = w; v.flush = f; v.rv = rv; v.tgt = t;
    v.addr = a; v.instr = i; v.pc4 = p4; v.valid = vl;
    v.scnt = sc; v.fcnt = fc; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_and_push(input vec_t v);
    Reset_n         = v.rst_n;
    PCWrite         = v.pcw;
    IFID_Write      = v.ifw;
    IF_Flush        = v.flush;
    redirect_valid  = v.rv;
    redirect_target = v.tgt;
    sb.push_back(v);
  endtask

  task automatic edge_and_compare(input string tag);
    vec_t e;
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " imem_addr"},   imem_addr,        e.addr);
      check({tag, " instr"},       IFID_Instruction, e.instr);
      check({tag, " pcplus4"},     IFID_PCPlus4,     e.pc4);
      check({tag, " valid"},       {31'd0, IFID_Valid},    {31'd0, e.valid});
      check({tag, " stall_count"}, stall_count,      e.scnt);
      check({tag, " flush_count"}, flush_count,      e.fcnt);
      check({tag, " timeout"},     {31'd0, stall_timeout}, {31'd0, e.to});
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge Clk);
    drive_and_push(v);
    edge_and_compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //            rst pcw ifw fl rv tgt            addr           instr          pc4            v  stall  flush  to
    vecs[0]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,         0, 0,  0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,         0, 0,  0, 0);
    vecs[2]  = mk(1, 1, 1, 0, 0, 32'h0,        32'h4,         32'h8C080004,  32'h4,         1, 0,  0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 0, 32'h0,        32'h8,         32'h8C080008,  32'h8,         1, 0,  0, 0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 32'h0,        32'hC,         32'h8C08000C,  32'hC,         1, 0,  0, 0);
    vecs[5]  = mk(1, 1, 1, 0, 0, 32'h0,        32'h10,        32'h8C080010,  32'h10,        1, 0,  0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h10,        32'h8C080010,  32'h10,        1, 1,  0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h10,        32'h8C080010,  32'h10,        1, 2,  0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h10,        32'h8C080010,  32'h10,        1, 3,  0, 0);
    vecs[9]  = mk(1, 1, 1, 0, 0, 32'h0,        32'h14,        32'h8C080014,  32'h14,        1, 3,  0, 0);
    vecs[10] = mk(1, 1, 1, 0, 0, 32'h0,        32'h18,        32'h8C080018,  32'h18,        1, 3,  0, 0);
    vecs[11] = mk(1, 1, 1, 0, 0, 32'h0,        32'h1C,        32'h8C08001C,  32'h1C,        1, 3,  0, 0);
    vecs[12] = mk(1, 1, 1, 0, 0, 32'h0,        32'h20,        32'h8C080020,  32'h20,        1, 3,  0, 0);
    vecs[13] = mk(1, 1, 1, 0, 1, 32'h107,      32'h104,       32'h0,         32'h0,         0, 3,  1, 0);
    vecs[14] = mk(1, 1, 1, 0, 0, 32'h0,        32'h108,       32'h8C080108,  32'h108,       1, 3,  1, 0);
    vecs[15] = mk(1, 1, 1, 0, 1, 32'h2E,       32'h2C,        32'h0,         32'h0,         0, 3,  2, 0);
    vecs[16] = mk(1, 1, 1, 0, 0, 32'h0,        32'h30,        32'h8C080030,  32'h30,        1, 3,  2, 0);
    vecs[17] = mk(1, 0, 0, 0, 1, 32'h200,      32'h30,        32'h8C080030,  32'h30,        1, 4,  2, 0);
    vecs[18] = mk(1, 0, 0, 1, 0, 32'h0,        32'h30,        32'h0,         32'h0,         0, 5,  3, 0);
    vecs[19] = mk(1, 1, 1, 0, 0, 32'h0,        32'h34,        32'h8C080034,  32'h34,        1, 5,  3, 0);
    vecs[20] = mk(1, 1, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC,  32'h0,         32'h0,         0, 5,  4, 0);
    vecs[21] = mk(1, 1, 1, 0, 0, 32'h0,        32'h0,         32'h8C080000,  32'h0,         1, 5,  4, 0);
    vecs[22] = mk(1, 0, 1, 0, 0, 32'h0,        32'h0,         32'h8C080004,  32'h4,         1, 6,  4, 0);
    vecs[23] = mk(1, 0, 1, 0, 0, 32'h0,        32'h0,         32'h8C080004,  32'h4,         1, 7,  4, 0);
    vecs[24] = mk(1, 0, 1, 0, 0, 32'h0,        32'h0,         32'h8C080004,  32'h4,         1, 8,  4, 0);
    vecs[25] = mk(1, 1, 1, 0, 0, 32'h0,        32'h4,         32'h8C080004,  32'h4,         1, 8,  4, 0);
    vecs[26] = mk(1, 0, 0, 0, 0, 32'h0,        32'h4,         32'h8C080004,  32'h4,         1, 9,  4, 0);
    vecs[27] = mk(1, 0, 0, 0, 0, 32'h0,        32'h4,         32'h8C080004,  32'h4,         1, 10, 4, 0);
    vecs[28] = mk(1, 0, 0, 0, 0, 32'h0,        32'h4,         32'h8C080004,  32'h4,         1, 11, 4, 0);
    vecs[29] = mk(1, 0, 0, 0, 0, 32'h0,        32'h4,         32'h8C080004,  32'h4,         1, 12, 4, 1);
    vecs[30] = mk(1, 1, 1, 0, 0, 32'h0,        32'h8,         32'h8C080008,  32'h8,         1, 12, 4, 1);
    vecs[31] = mk(1, 1, 1, 0, 0, 32'h0,        32'hC,         32'h8C08000C,  32'hC,         1, 12, 4, 1);

    Reset_n = 1'b0; PCWrite = 1'b1; IFID_Write = 1'b1; IF_Flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;

    for (int i = 0; i < 32; i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of a stall, redirect and flush clears everything.
    step(mk(0, 0, 0, 1, 1, 32'h500, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0), "rst_mid");

    // After release and before the first edge: fetch address is RESET_PC, IF/ID empty.
    @(negedge Clk);
    drive_and_push(mk(1, 1, 1, 0, 0, 32'h0, 32'h4, 32'h8C080004, 32'h4, 1, 0, 0, 0));
    #1;
    check("pre_edge imem_addr", imem_addr, 32'h0);
    check("pre_edge valid", {31'd0, IFID_Valid}, 32'd0);
    edge_and_compare("post_rst");

    // A single-cycle stall followed by normal fetch does not trip the watchdog.
    step(mk(1, 0, 1, 0, 0, 32'h0, 32'h4, 32'h8C080008, 32'h8, 1, 1, 0, 0), "short_stall");
    step(mk(1, 1, 1, 0, 0, 32'h0, 32'h8, 32'h8C080008, 32'h8, 1, 1, 0, 0), "short_rel");

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
